local_store_loader: RTL and testbench
=====================================

LOCAL_STORE_LOADER -- requirements
Module: local_store_loader

Interface
REQ-001 SHALL have parameter L, default `L, elements packed per store word.
REQ-002 SHALL have parameter WIDTH, default `WIDTH, bits per element.
REQ-003 SHALL have parameter WORDS, default `B/`L, store words per block load.
REQ-004 SHALL have parameter AW, default `ADDR_WIDTH, store address width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  begin a block load; sampled only in IDLE.
REQ-008 SHALL have port in_valid  input  1  in_data holds an element.
REQ-009 SHALL have port in_data  input  WIDTH  element stream.
REQ-010 SHALL have port in_ready  output  1  loader accepts an element this cycle.
REQ-011 SHALL have port flush  input  1  terminate the load early; effective only with LOADER_PAD_EN.
REQ-012 SHALL have port we  output  1  store write strobe.
REQ-013 SHALL have port a_w  output  AW  store write address.
REQ-014 SHALL have port di  output  L*WIDTH  store write data.
REQ-015 SHALL have port busy  output  1  high in LOAD.
REQ-016 SHALL have port done  output  1  one-cycle pulse on load completion.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-018 SHALL transition IDLE->LOAD on start=1, clearing lane counter and word address to 0.
REQ-019 SHALL drive in_ready=1 only in LOAD; an element is accepted when in_valid and in_ready are both high.
REQ-020 SHALL place the accepted element in lane k at bits [k*WIDTH+WIDTH-1 : k*WIDTH]; lane 0 first, lane counter wraps from L-1 to 0.
REQ-021 SHALL, on accepting the element into lane L-1, assert we=1 on the next cycle only, with a_w equal to the word address and di equal to the full packed word.
REQ-022 SHALL increment the word address after each write; when the write to WORDS-1 is issued, SHALL go LOAD->DONE.
REQ-023 SHALL sustain one accepted element per cycle with no bubbles, including across word boundaries and for L=1.
REQ-024 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-025 SHALL ignore start outside IDLE and in_valid outside LOAD.
REQ-026 SHALL hold di and a_w stable when we=0; they carry no meaning then.
REQ-027 SHALL never issue a write to an address >= WORDS.

Reset
REQ-028 SHALL, on reset_n=0, immediately enter IDLE and force we=0, in_ready=0, busy=0, done=0, a_w=0, di=0, lane counter=0.
REQ-029 SHALL discard any partially packed word when reset is asserted mid-load; no write is issued for it.

Configuration
REQ-030 SHALL provide macro LOADER_PAD_EN; when it is defined, flush=1 in LOAD with lane counter !=0 SHALL write the partial word, with unfilled lanes set to all-ones (infinite distance), then go to DONE.
REQ-031 With LOADER_PAD_EN defined, flush=1 in LOAD with lane counter=0 SHALL go to DONE with no write.
REQ-032 With LOADER_PAD_EN defined, an element accepted in the same cycle as flush SHALL be packed before padding.
REQ-033 Without LOADER_PAD_EN, flush SHALL be ignored and pad logic SHALL be absent.

Verification (L=4, WIDTH=8, WORDS=4)
REQ-034 Scenario: start, then 16 elements 0x00..0x0F streamed back-to-back -> writes at a_w 0..3 with di 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; each write one cycle after its lane-3 accept; done pulses once.
REQ-035 Scenario: in_valid toggling 1/0 every cycle -> identical four writes, no spurious we, in_ready stays 1 through LOAD.
REQ-036 Scenario: reset_n low after 6 accepted elements -> outputs cleared immediately; after restart with 0x10..0x1F, first write is a_w=0, di=0x13121110.
REQ-037 Scenario: start held high through DONE -> a new load begins only after the IDLE re-entry; no second done in the same load.
REQ-038 Scenario (LOADER_PAD_EN): flush with the 6th element 0x05 -> write a_w=1, di=0xFFFF0504, then done; without the macro, the same stimulus leaves the load running.

Source files
------------

// File: rtl/local_store_loader.sv
`default_nettype none
// ============================================================================
// local_store_loader : packs an element stream into L-lane store words and
// writes WORDS of them per block load.  Optional macro LOADER_PAD_EN.
// Rev 1.0
// ============================================================================
`ifndef L
`define L 4
`endif
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef B
`define B 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module local_store_loader #(
  parameter int L     = `L,
  parameter int WIDTH = `WIDTH,
  parameter int WORDS = `B / `L,
  parameter int AW    = `ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  input  logic               flush,
  output logic               we,
  output logic [AW-1:0]      a_w,
  output logic [L*WIDTH-1:0] di,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;
  localparam int         c_LW   = (L > 1) ? $clog2(L) : 1;
  localparam int         c_DW   = L * WIDTH;
`ifdef LOADER_PAD_EN
  // Unfilled lanes read as all-ones (infinite distance) when a partial word is flushed.
  localparam logic [c_DW-1:0] c_FILL = '1;
`else
  localparam logic [c_DW-1:0] c_FILL = '0;
`endif

  logic [1:0]      state_q, state_d;
  logic [c_LW-1:0] lane_q, lane_d;
  logic [AW-1:0]   word_q, word_d;
  logic [c_DW-1:0] pack_q, pack_d;
  logic            we_q, we_d;
  logic [AW-1:0]   a_w_q, a_w_d;
  logic [c_DW-1:0] di_q, di_d;

  logic            w_accept;
  logic            w_last_lane;
  logic [c_DW-1:0] w_merged;

`ifndef LOADER_PAD_EN
  logic w_unused_flush;
  assign w_unused_flush = flush;
`endif

  assign w_accept    = (state_q == c_LOAD) && in_valid;
  assign w_last_lane = (lane_q == c_LW'(L - 1));

  always_comb begin
    w_merged = pack_q;
    for (int k = 0; k < L; k++) begin
      if (lane_q == c_LW'(k)) w_merged[k*WIDTH +: WIDTH] = in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    pack_d  = pack_q;
    we_d    = 1'b0;
    a_w_d   = a_w_q;
    di_d    = di_q;
    case (state_q)
      c_IDLE: begin
        if (start) begin
          state_d = c_LOAD;
          lane_d  = '0;
          word_d  = '0;
          pack_d  = c_FILL;
        end
      end
      c_LOAD: begin
        if (w_accept) begin
          if (w_last_lane) begin
            we_d   = 1'b1;
            a_w_d  = word_q;
            di_d   = w_merged;
            word_d = word_q + AW'(1);
            lane_d = '0;
            pack_d = c_FILL;
            if (word_q == AW'(WORDS - 1)) state_d = c_DONE;
          end else begin
            lane_d = lane_q + c_LW'(1);
            pack_d = w_merged;
          end
        end
`ifdef LOADER_PAD_EN
        // An element arriving with flush is merged first; a word it completes is written normally.
        if (flush) begin
          state_d = c_DONE;
          if (!(w_accept && w_last_lane) && (w_accept || lane_q != '0)) begin
            we_d  = 1'b1;
            a_w_d = word_q;
            di_d  = w_accept ? w_merged : pack_q;
          end
        end
`endif
      end
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      pack_q  <= c_FILL;
      we_q    <= 1'b0;
      a_w_q   <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      pack_q  <= pack_d;
      we_q    <= we_d;
      a_w_q   <= a_w_d;
      di_q    <= di_d;
    end
  end

  assign in_ready = (state_q == c_LOAD);
  assign busy     = (state_q == c_LOAD);
  assign done     = (state_q == c_DONE);
  assign we       = we_q;
  assign a_w      = a_w_q;
  assign di       = di_q;

endmodule

`default_nettype wire

// File: tb/tb_local_store_loader.sv
`default_nettype none
// ============================================================================
// tb_local_store_loader : randomized self-checking bench with a queue-based
// reference model of the loader (L=4, WIDTH=8, WORDS=4).
// Rev 1.0
// ============================================================================
module tb_local_store_loader;

  localparam int P_L     = 4;
  localparam int P_WIDTH = 8;
  localparam int P_WORDS = 4;
  localparam int P_AW    = 4;
  localparam int P_DW    = P_L * P_WIDTH;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              in_valid;
  logic [P_WIDTH-1:0] in_data;
  logic              in_ready;
  logic              flush;
  logic              we;
  logic [P_AW-1:0]   a_w;
  logic [P_DW-1:0]   di;
  logic              busy;
  logic              done;

  local_store_loader #(
    .L    (P_L),
    .WIDTH(P_WIDTH),
    .WORDS(P_WORDS),
    .AW   (P_AW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .flush   (flush),
    .we      (we),
    .a_w     (a_w),
    .di      (di),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 idle, 1 load, 2 done; accepted elements queued per word.
  int                 m_phase;
  int                 m_n;
  int                 m_words;
  logic [P_WIDTH-1:0] m_lanes[$];
  bit                 m_we;
  logic [P_AW-1:0]    m_aw;
  logic [P_DW-1:0]    m_di;

  logic [P_AW-1:0]    log_aw[$];
  logic [P_DW-1:0]    log_di[$];
  int                 dut_dones = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_n     = 0;
    m_words = 0;
    m_lanes.delete();
    m_we    = 1'b0;
    m_aw    = '0;
    m_di    = '0;
  endtask

  task automatic model_emit(output bit wr);
    logic [P_DW-1:0] w;
    w = '1;
    for (int k = 0; k < m_lanes.size(); k++) w[k*P_WIDTH +: P_WIDTH] = m_lanes[k];
    m_aw = P_AW'(m_words);
    m_di = w;
    m_words++;
    m_lanes.delete();
    wr = 1'b1;
  endtask

  task automatic model_update(input bit s, input bit v, input logic [P_WIDTH-1:0] d, input bit f);
    bit wr;
    wr = 1'b0;
    case (m_phase)
      0: if (s) begin
        m_phase = 1;
        m_n     = 0;
        m_words = 0;
        m_lanes.delete();
      end
      1: begin
        if (v) begin
          m_lanes.push_back(d);
          m_n++;
          if (m_lanes.size() == P_L) begin
            model_emit(wr);
            if (m_words == P_WORDS) m_phase = 2;
          end
        end
`ifdef LOADER_PAD_EN
        if (f && m_phase == 1) begin
          if (m_lanes.size() > 0) model_emit(wr);
          m_phase = 2;
        end
`else
        if (f) m_phase = m_phase;
`endif
      end
      default: m_phase = 0;
    endcase
    m_we = wr;
  endtask

  task automatic step(input bit s, input bit v, input logic [P_WIDTH-1:0] d, input bit f);
    start    = s;
    in_valid = v;
    in_data  = d;
    flush    = f;
    @(negedge clk);
    check("in_ready", in_ready, m_phase == 1);
    check("busy", busy, m_phase == 1);
    check("done", done, m_phase == 2);
    check("we", we, m_we);
    check("a_w", a_w, m_aw);
    check("di", di, m_di);
    if (we === 1'b1) begin
      log_aw.push_back(a_w);
      log_di.push_back(di);
    end
    if (done === 1'b1) dut_dones++;
    model_update(s, v, d, f);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    check("rst_we", we, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_a_w", a_w, 0);
    check("rst_di", di, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // mode 0: back-to-back, mode 1: valid toggles, mode 2: random valid/data/flush.
  task automatic run_load(input int mode, input logic [P_WIDTH-1:0] base, input bit hold_start,
                          input int flush_at, input int abort_after);
    bit                 v;
    bit                 f;
    bit                 seen_done;
    bit                 finished;
    logic [P_WIDTH-1:0] d;
    int                 dones0;
    dones0    = dut_dones;
    seen_done = 1'b0;
    finished  = 1'b0;
    step(1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < 400; c++) begin
      if (abort_after > 0 && m_n == abort_after) begin
        do_reset();
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (c % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = (mode == 2) ? P_WIDTH'($urandom) : base + P_WIDTH'(m_n);
      f = (flush_at > 0 && m_n == flush_at - 1 && v) || (mode == 2 && $urandom_range(0, 15) == 0);
      step(hold_start, v, d, f);
      if (m_phase == 2) seen_done = 1'b1;
      if (seen_done && m_phase == 0) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) check("load_timeout", 0, 1);
    check("done_pulses", dut_dones - dones0, 1);
  endtask

  logic [P_DW-1:0] exp_s1 [4];

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    model_reset();
    exp_s1[0] = 32'h03020100;
    exp_s1[1] = 32'h07060504;
    exp_s1[2] = 32'h0B0A0908;
    exp_s1[3] = 32'h0F0E0D0C;
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back 0x00..0x0F
    log_aw.delete(); log_di.delete();
    run_load(0, 8'h00, 1'b0, 0, 0);
    check("s1_nwr", log_di.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_di.size()) begin
        check("s1_di", log_di[i], exp_s1[i]);
        check("s1_aw", log_aw[i], i);
      end
    end

    // Toggling valid gives the same words
    log_aw.delete(); log_di.delete();
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    run_load(1, 8'h00, 1'b0, 0, 0);
    check("s2_nwr", log_di.size(), 4);
    if (log_di.size() == 4) check("s2_last", log_di[3], exp_s1[3]);

    // Reset after 6 accepts, then restart with 0x10..0x1F
    run_load(0, 8'h00, 1'b0, 0, 6);
    log_aw.delete(); log_di.delete();
    run_load(0, 8'h10, 1'b0, 0, 0);
    check("s3_nwr", log_di.size(), 4);
    if (log_di.size() > 0) begin
      check("s3_first_di", log_di[0], 32'h13121110);
      check("s3_first_aw", log_aw[0], 0);
    end

    // Start held high through DONE
    run_load(0, 8'h20, 1'b1, 0, 0);
    step(1'b1, 1'b0, '0, 1'b0);
    run_load(1, 8'h30, 1'b0, 0, 0);

    // Flush with the 6th element
    log_aw.delete(); log_di.delete();
    run_load(0, 8'h00, 1'b0, 6, 0);
`ifdef LOADER_PAD_EN
    check("s5_nwr", log_di.size(), 2);
    if (log_di.size() == 2) begin
      check("s5_pad_di", log_di[1], 32'hFFFF0504);
      check("s5_pad_aw", log_aw[1], 1);
    end
`else
    check("s5_nwr", log_di.size(), 4);
    if (log_di.size() == 4) check("s5_di1", log_di[1], exp_s1[1]);
`endif

    // Randomized loads with idle gaps carrying ignored valid/flush
    for (int r = 0; r < 8; r++) begin
      int gap;
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++)
        step(1'b0, 1'($urandom_range(0, 1)), P_WIDTH'($urandom), 1'($urandom_range(0, 1)));
      run_load(2, 8'h00, 1'b0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
